// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter driving a registered mux select and one valid/ready output port.
// Optional per-requester transfer counters on grant_cnt when RR_ARB_PERF_EN is defined.
module rr_mux_arbiter #(
  parameter int N_INPUTS = 2,
  parameter int DWIDTH = 8,
  localparam int SW = $clog2(N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_INPUTS-1:0] req_valid,
  input  logic [DWIDTH-1:0] req_data [N_INPUTS],
  output logic [N_INPUTS-1:0] req_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [SW-1:0]     sel,
`ifdef RR_ARB_PERF_EN
  output logic              busy,
  output logic [15:0]       grant_cnt [N_INPUTS]
`else
  output logic              busy
`endif
);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, sel_q, sel_d, nxt_ptr, start, win;
  logic xfer, found;
  int idx;
  assign busy = state_q == GRANT;
  assign sel = sel_q;
  assign out_valid = busy && req_valid[sel_q];
  assign out_data = req_data[sel_q];
  assign xfer = out_valid && out_ready;
  assign nxt_ptr = (sel_q == SW'(N_INPUTS - 1)) ? '0 : sel_q + 1'b1;
  assign start = busy ? nxt_ptr : ptr_q;
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) req_ready[i] = busy && out_ready && sel_q == SW'(i);
  end
  // In GRANT the search only matters on a transfer, so it always skips the current sel.
  always_comb begin
    found = 1'b0;
    win = sel_q;
    idx = 0;
    for (int i = 0; i < N_INPUTS; i++) begin
      idx = (int'(start) + i >= N_INPUTS) ? int'(start) + i - N_INPUTS : int'(start) + i;
      if (!found && req_valid[idx] && !(busy && idx == int'(sel_q))) begin
        found = 1'b1;
        win = SW'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    if (!busy) begin
      sel_d = found ? win : sel_q;
      state_d = found ? GRANT : IDLE;
    end else if (xfer) begin
      ptr_d = nxt_ptr;
      sel_d = win;
      state_d = found ? GRANT : IDLE;
    end else if (!req_valid[sel_q]) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
    end
  end
`ifdef RR_ARB_PERF_EN
  logic [15:0] cnt_q [N_INPUTS];
  logic [15:0] cnt_d [N_INPUTS];
  assign grant_cnt = cnt_q;
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++)
      cnt_d[i] = (xfer && sel_q == SW'(i) && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed self-checking bench for rr_mux_arbiter with three requesters.
module tb_rr_mux_arbiter;
  localparam int N = 3;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [W-1:0] req_data [N];
  logic out_valid, out_ready, busy;
  logic [W-1:0] out_data;
  logic [1:0] sel;
  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.N_INPUTS(N), .DWIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    step;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] rr_sel [5];
    logic [W-1:0] rr_data [3];
    rr_sel = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rr_data = '{8'h10, 8'h20, 8'h30};
    req_data = '{8'h10, 8'h20, 8'h30};
    out_ready = 1'b0;
    req_valid = 3'b111;
    step;
    step;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step;
    chk("first_sel", 32'(sel), 0);
    chk("first_out_valid", 32'(out_valid), 1);
    chk("first_ready", 32'(req_ready), 32'b001);
    chk("first_data", 32'(out_data), 32'h10);
    for (int k = 0; k < 5; k++) begin
      step;
      chk("rr_sel", 32'(sel), 32'(rr_sel[k]));
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_data", 32'(out_data), 32'(rr_data[rr_sel[k]]));
    end

    do_reset;
    req_valid = 3'b010;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("lone_busy", 32'(busy), (k % 2 == 0) ? 1 : 0);
      chk("lone_valid", 32'(out_valid), (k % 2 == 0) ? 1 : 0);
      chk("lone_sel", 32'(sel), 1);
    end

    do_reset;
    req_data[2] = 8'hA5;
    req_valid = 3'b100;
    step;
    for (int k = 0; k < 5; k++) begin
      chk("stall_sel", 32'(sel), 2);
      chk("stall_data", 32'(out_data), 32'hA5);
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_busy", 32'(busy), 1);
      step;
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(req_ready), 32'b100);
    step;
    chk("after_xfer_busy", 32'(busy), 0);
    req_valid = 3'b110;
    step;
    chk("wrap_ptr_sel", 32'(sel), 1);

    do_reset;
    req_valid = 3'b001;
    step;
    chk("drop_granted", 32'(sel), 0);
    req_valid = 3'b000;
    #1;
    chk("drop_out_valid", 32'(out_valid), 0);
    step;
    chk("drop_idle", 32'(busy), 0);
    req_valid = 3'b101;
    step;
    chk("drop_ptr_sel", 32'(sel), 0);

    do_reset;
    req_valid = 3'b010;
    out_ready = 1'b1;
    step;
    step;
    req_valid = 3'b100;
    out_ready = 1'b0;
    step;
    chk("midrst_pre_sel", 32'(sel), 2);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    step;
    rst_n = 1'b1;
    req_valid = 3'b101;
    out_ready = 1'b0;
    step;
    chk("midrst_rearb_sel", 32'(sel), 0);
    chk("midrst_rearb_busy", 32'(busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
